// File: rtl/writeback_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Port A (pipeline) always wins; port B results are queued in an in-order FIFO
// and drained on cycles without an A result. Optional same-cycle read bypass
// is compiled in when WB_BYPASS_EN is defined.
module writeback_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_a_valid,
  input  logic [4:0]      i_a_addr,
  input  logic [XLEN-1:0] i_a_data,
  input  logic            i_b_valid,
  output logic            o_b_ready,
  input  logic [4:0]      i_b_addr,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_WE3,
  output logic [4:0]      o_A3_addr,
  output logic [XLEN-1:0] o_WD3_data,
  output logic [31:0]     o_pending,
  output logic            o_stall_req,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [XLEN-1:0] i_rf_rd1,
  input  logic [XLEN-1:0] i_rf_rd2,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      addr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;
  logic [PTR_W-1:0] slot_ofs;

  logic fifo_nonempty;
  logic push;
  logic pop;
  logic starve_inc;

  assign o_b_ready     = (count != CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (count != '0);
  // Writes to x0 are accepted from port B but never occupy a slot.
  assign push          = i_b_valid && o_b_ready && (i_b_addr != '0);
  assign pop           = !i_a_valid && fifo_nonempty;
  assign starve_inc    = i_a_valid && fifo_nonempty;

  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= i_b_addr;
      data_mem[wr_ptr] <= i_b_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_WE3      <= 1'b0;
      o_A3_addr  <= '0;
      o_WD3_data <= '0;
    end else if (i_a_valid) begin
      o_WE3      <= (i_a_addr != '0);
      o_A3_addr  <= i_a_addr;
      o_WD3_data <= i_a_data;
    end else if (fifo_nonempty) begin
      o_WE3      <= 1'b1;
      o_A3_addr  <= addr_mem[rd_ptr];
      o_WD3_data <= data_mem[rd_ptr];
    end else begin
      o_WE3      <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt  <= '0;
      o_stall_req <= 1'b0;
    end else begin
      if (pop || !fifo_nonempty) begin
        starve_cnt <= '0;
      end else if (starve_inc && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
      o_stall_req <= ((starve_cnt == STV_W'(STARVE_LIMIT - 1)) && starve_inc) ||
                     ((starve_cnt == STV_W'(STARVE_LIMIT)) && fifo_nonempty);
    end
  end

  // A physical slot is live when its distance from the head is below the count.
  always_comb begin
    o_pending = '0;
    slot_ofs  = '0;
    for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
      slot_ofs = PTR_W'(j) - rd_ptr;
      if ({1'b0, slot_ofs} < count) begin
        o_pending[addr_mem[j]] = 1'b1;
      end
    end
    o_pending[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  assign o_rs1_data = (o_WE3 && (o_A3_addr == i_rs1_addr) && (i_rs1_addr != '0)) ?
                      o_WD3_data : i_rf_rd1;
  assign o_rs2_data = (o_WE3 && (o_A3_addr == i_rs2_addr) && (i_rs2_addr != '0)) ?
                      o_WD3_data : i_rf_rd2;
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{i_rs1_addr, i_rs2_addr};
  assign o_rs1_data     = i_rf_rd1;
  assign o_rs2_data     = i_rf_rd2;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter. Register-file writes
// expected by a queue-based reference model are pushed into a scoreboard and
// popped by an independent monitor whenever the DUT asserts o_WE3.
module tb_writeback_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIM   = 8;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_a_valid = 1'b0;
  logic [4:0]      i_a_addr = '0;
  logic [XLEN-1:0] i_a_data = '0;
  logic            i_b_valid = 1'b0;
  logic            o_b_ready;
  logic [4:0]      i_b_addr = '0;
  logic [XLEN-1:0] i_b_data = '0;
  logic            o_WE3;
  logic [4:0]      o_A3_addr;
  logic [XLEN-1:0] o_WD3_data;
  logic [31:0]     o_pending;
  logic            o_stall_req;
  logic [4:0]      i_rs1_addr = '0;
  logic [4:0]      i_rs2_addr = '0;
  logic [XLEN-1:0] i_rf_rd1 = '0;
  logic [XLEN-1:0] i_rf_rd2 = '0;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;

  int checks = 0;
  int failures = 0;

  // Reference model state
  wb_t         mq[$];
  wb_t         sb[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd3 = '0;
  int          m_starve = 0;
  logic        m_stall = 1'b0;

  writeback_arbiter #(
    .XLEN(32),
    .FIFO_DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_a_valid(i_a_valid),
    .i_a_addr(i_a_addr),
    .i_a_data(i_a_data),
    .i_b_valid(i_b_valid),
    .o_b_ready(o_b_ready),
    .i_b_addr(i_b_addr),
    .i_b_data(i_b_data),
    .o_WE3(o_WE3),
    .o_A3_addr(o_A3_addr),
    .o_WD3_data(o_WD3_data),
    .o_pending(o_pending),
    .o_stall_req(o_stall_req),
    .i_rs1_addr(i_rs1_addr),
    .i_rs2_addr(i_rs2_addr),
    .i_rf_rd1(i_rf_rd1),
    .i_rf_rd2(i_rf_rd2),
    .o_rs1_data(o_rs1_data),
    .o_rs2_data(o_rs2_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(posedge i_clk) begin
    #1;
    if (i_rst_n && o_WE3) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual=%0h:%0h required=none", o_A3_addr, o_WD3_data);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_write", {o_A3_addr, o_WD3_data}, {e.addr, e.data});
      end
    end
  end

  function automatic logic [31:0] exp_pending();
    logic [31:0] p;
    p = '0;
    foreach (mq[k]) p[mq[k].addr] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic [31:0] exp_rs(input logic [4:0] ra, input logic [31:0] rd);
`ifdef WB_BYPASS_EN
    if (m_we && (m_a3 == ra) && (ra != 5'd0)) return m_wd3;
`endif
    return rd;
  endfunction

  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d1, input logic [31:0] d2);
    bit  ne;
    bit  rdy;
    bit  inc;
    bit  popped;
    bit  nstall;
    wb_t e;
    @(negedge i_clk);
    i_a_valid = av; i_a_addr = aa; i_a_data = ad;
    i_b_valid = bv; i_b_addr = ba; i_b_data = bd;
    i_rs1_addr = r1; i_rs2_addr = r2; i_rf_rd1 = d1; i_rf_rd2 = d2;
    #1;
    ne  = (mq.size() != 0);
    rdy = (mq.size() != DEPTH);
    chk("b_ready", o_b_ready, rdy);
    chk("pending", o_pending, exp_pending());
    chk("stall_req", o_stall_req, m_stall);
    chk("WE3", o_WE3, m_we);
    chk("A3_hold", o_A3_addr, m_a3);
    chk("WD3_hold", o_WD3_data, m_wd3);
    chk("rs1_data", o_rs1_data, exp_rs(r1, d1));
    chk("rs2_data", o_rs2_data, exp_rs(r2, d2));
    inc    = av && ne;
    popped = 1'b0;
    nstall = ((m_starve == LIM - 1) && inc) || ((m_starve == LIM) && ne);
    if (av) begin
      m_we = (aa != 5'd0); m_a3 = aa; m_wd3 = ad;
      if (m_we) sb.push_back('{aa, ad});
    end else if (ne) begin
      e = mq.pop_front();
      m_we = 1'b1; m_a3 = e.addr; m_wd3 = e.data;
      sb.push_back(e);
      popped = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (popped || !ne) m_starve = 0;
    else if (inc && m_starve < LIM) m_starve++;
    m_stall = nstall;
    if (bv && rdy && ba != 5'd0) mq.push_back('{ba, bd});
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_a_valid = 1'b0; i_b_valid = 1'b0;
    #1;
    chk("rst_WE3", o_WE3, 1'b0);
    chk("rst_A3", o_A3_addr, 5'd0);
    chk("rst_WD3", o_WD3_data, 32'd0);
    chk("rst_b_ready", o_b_ready, 1'b1);
    chk("rst_pending", o_pending, 32'd0);
    chk("rst_stall", o_stall_req, 1'b0);
    mq.delete(); sb.delete();
    m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_starve = 0; m_stall = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int pa;
    logic [4:0] r1;
    do_reset();

    // A only, including a write to x0
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    cycle(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    idle();

    // B into empty FIFO with A idle
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBEEF, 5'd0, 5'd0, 32'd0, 32'd0);
    idle(); idle();

    // Fill the FIFO under continuous A traffic, starve, then drain
    for (int unsigned i = 0; i < 12; i++)
      cycle(1'b1, 5'(20 + (i % 8)), 32'hA000 + i, 1'b1, 5'(10 + i), 32'hB000 + i,
            5'd0, 5'd0, 32'd0, 32'd0);
    repeat (6) idle();

    // Push and pop together at count 2, then a B write to x0
    cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd12, 32'hC1, 5'd0, 5'd0, 32'd0, 32'd0);
    cycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd13, 32'hC2, 5'd0, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'hC3, 5'd0, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0, 32'd0, 32'd0);
    repeat (4) idle();

    // Reset with three queued entries
    for (int unsigned i = 0; i < 3; i++)
      cycle(1'b1, 5'(24 + i), 32'hE0 + i, 1'b1, 5'(16 + i), 32'hF0 + i,
            5'd0, 5'd0, 32'd0, 32'd0);
    do_reset();

    // Write followed by a read of the same register
    cycle(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 32'h11, 32'h22);
    idle();

    // Randomized phases with varying A pressure
    for (int unsigned i = 0; i < 2000; i++) begin
      case ((i / 100) % 4)
        0: pa = 50;
        1: pa = 95;
        2: pa = 10;
        default: pa = 100;
      endcase
      r1 = ($urandom_range(1, 0) != 0) ? m_a3 : 5'($urandom);
      cycle($urandom_range(99, 0) < pa, 5'($urandom), $urandom,
            $urandom_range(99, 0) < 60, 5'($urandom), $urandom,
            r1, 5'($urandom), $urandom, $urandom);
    end

    for (int unsigned i = 0; i < 16 && mq.size() != 0; i++) idle();
    chk("fifo_drained", mq.size(), 0);
    idle();
    @(posedge i_clk);
    #2;
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
